param_stack: RTL
================

// Module: param_stack
// PURPOSE
//   Parametrised LIFO stack: generalised width and depth, with full/empty
//   flags, occupancy count, defined simultaneous push+pop and sticky
//   overflow/underflow errors. Successor to the fixed 8-bit stack.
//   Serves as the operand/return stack for datapath blocks in the design.
// PARAMETERS
//   WIDTH  8  data word width in bits (>=1)
//   DEPTH  8  number of entries (>=2; need not be a power of 2)
//   CW     $clog2(DEPTH+1)  count width (localparam, derived)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   push       in   1      push data_in this cycle
//   data_in    in   WIDTH  word to push
//   pop        in   1      pop top entry this cycle
//   clr_err    in   1      synchronous clear of overflow/underflow
//   data_out   out  WIDTH  registered top-of-stack; 0 when empty
//   empty      out  1      count == 0
//   full       out  1      count == DEPTH
//   count      out  CW     number of valid entries
//   overflow   out  1      sticky: push to full stack was dropped
//   underflow  out  1      sticky: pop of empty stack was ignored
// BEHAVIOUR
//   - Reset (async, immediate): count=0, data_out=0, empty=1, full=0,
//     overflow=0, underflow=0. Memory contents are not reset.
//   - Release: first state change on the first clk edge with rst low.
//   - All updates on posedge clk; data_out/flags/count show the post-op
//     state one edge after the request (latency 1, no combinational
//     path from inputs to outputs).
//   - push only, not full: mem[count]<=data_in; count+1; data_out<=data_in.
//   - push only, full: no write, count unchanged, overflow<=1.
//   - pop only, count>1: count-1; data_out<=mem[count-2].
//   - pop only, count==1: count=0; data_out<=0.
//   - pop only, empty: no change, underflow<=1.
//   - push+pop, non-empty (incl. full): replace top: mem[count-1]<=data_in,
//     count unchanged, data_out<=data_in, no error.
//   - push+pop, empty: treated as push-only (count=1), no underflow.
//   - clr_err: clears both sticky flags; an error event in the same cycle
//     wins (flag ends set).
//   - Errors never corrupt state; the stack remains usable afterwards.
//   - Reset asserted mid-operation: the in-flight op is discarded and
//     state goes to reset values asynchronously.
//   - count arithmetic is CW bits wide; never wraps (guarded by
//     full/empty).
// CONFIGURATION
//   PARAM_STACK_WATERMARK_EN
//     defined: extra output max_count [CW-1:0], the high-water mark of
//       count since reset or clr_err; updates on the same edge as count
//       (max_count <= max(max_count, next count)); reset 0; clr_err
//       loads the current next count.
//     undefined: port and logic absent; all other behaviour identical.
// TESTING  (WIDTH=8, DEPTH=4 unless noted)
//   1 reset, push 7 then push 5 -> data_out 7 then 5; count 1,2;
//     pop -> data_out=7, count=1; pop -> data_out=0, empty=1.
//   2 push 1,2,3,4 -> full=1, count=4; push 9 -> overflow=1,
//     data_out=4, count=4; pops return 3,2,1,0 (empty).
//   3 pop on empty -> underflow=1, count=0; clr_err -> underflow=0;
//     clr_err with pop on empty in same cycle -> underflow stays 1.
//   4 push 10, then push+pop with data_in 20 -> count=1, data_out=20;
//     on full stack push+pop with 33 -> count=4, data_out=33,
//     no overflow; on empty push+pop with 44 -> count=1, data_out=44.
//   5 push 3 values, assert rst between edges -> outputs 0/empty=1
//     immediately, before the next clk edge; push 6 after release
//     -> data_out=6, count=1.
//   6 WATERMARK_EN: push 3, pop 2 -> max_count=3, count=1; clr_err
//     -> max_count=1. Without the macro the same bench (less
//     max_count) passes.

Source files
------------

// File: rtl/param_stack.sv
// Parametrised LIFO stack with flags, occupancy count and sticky errors.
// Define PARAM_STACK_WATERMARK_EN to add the max_count high-water output.
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
`ifdef PARAM_STACK_WATERMARK_EN
    ,
    output logic [CW-1:0]    max_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] TWO    = CW'(2);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] dout_q, dout_n;
    logic             ov_q, un_q;
    logic             ov_ev, un_ev;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == FULL_C);
    assign count     = cnt_q;
    assign data_out  = dout_q;
    assign overflow  = ov_q;
    assign underflow = un_q;

    // Entry just below the current top, exposed when popping
    assign rd_idx = AW'(cnt_q - TWO);

    always_comb begin
        cnt_n  = cnt_q;
        dout_n = dout_q;
        wr_en  = 1'b0;
        wr_idx = AW'(cnt_q);
        ov_ev  = 1'b0;
        un_ev  = 1'b0;
        if (push && pop && !empty) begin
            // Replace top in place; count unchanged
            wr_en  = 1'b1;
            wr_idx = AW'(cnt_q - ONE);
            dout_n = data_in;
        end else if (push && !full) begin
            wr_en  = 1'b1;
            wr_idx = AW'(cnt_q);
            cnt_n  = cnt_q + ONE;
            dout_n = data_in;
        end else if (push) begin
            ov_ev = 1'b1;
        end else if (pop && cnt_q == ONE) begin
            cnt_n  = '0;
            dout_n = '0;
        end else if (pop && !empty) begin
            cnt_n  = cnt_q - ONE;
            dout_n = mem[rd_idx];
        end else if (pop) begin
            un_ev = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            dout_q <= '0;
            ov_q   <= 1'b0;
            un_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            dout_q <= dout_n;
            ov_q   <= ov_ev | (ov_q & ~clr_err);
            un_q   <= un_ev | (un_q & ~clr_err);
        end
    end

`ifdef PARAM_STACK_WATERMARK_EN
    logic [CW-1:0] max_q;

    assign max_count = max_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
        end else if (clr_err) begin
            max_q <= cnt_n;
        end else if (cnt_n > max_q) begin
            max_q <= cnt_n;
        end
    end
`else
    // No high-water tracking in this build
`endif

endmodule
